// File: rtl/fetch_instr_queue_if.sv
// Shared fetch/rename instruction record and the queue's handshake bundle.
// Fetch/rename drive the master side; the queue is the slave.
package fetch_instr_queue_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        br_taken_pred;
  } pc_instr_t;
endpackage

interface fetch_instr_queue_if
  import fetch_instr_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ENQ_W = 2,
  parameter int DEQ_W = 2
);
  logic [ENQ_W-1:0]             enq_valid;
  pc_instr_t [ENQ_W-1:0]        enq_data;
  logic                         enq_ready;
  logic [DEQ_W-1:0]             deq_valid;
  pc_instr_t [DEQ_W-1:0]        deq_data;
  logic [$clog2(DEQ_W+1)-1:0]   deq_take;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output enq_valid, enq_data, deq_take,
    input  enq_ready, deq_valid, deq_data, count
  );

  modport slave (
    input  enq_valid, enq_data, deq_take,
    output enq_ready, deq_valid, deq_data, count
  );
endinterface

// File: rtl/fetch_instr_queue.sv
// Fetch-to-rename decoupling FIFO: multi-lane enqueue, in-order
// multi-lane dequeue, single-cycle flush on mispredict.
module fetch_instr_queue
  import fetch_instr_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ENQ_W = 2,
  parameter int DEQ_W = 2
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  fetch_instr_queue_if.slave q
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(ENQ_W + 1);
  localparam int TW = $clog2(DEQ_W + 1);

  pc_instr_t     mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt;
  logic [NW-1:0] n_enq;
  logic [TW-1:0] n_deq;
  logic          ready;
  logic          fire;

  assign cnt   = CW'(tail_q - head_q);
  assign ready = (DEPTH - int'(cnt)) >= ENQ_W;
  assign fire  = ready && !flush;

  // Group size is the run of valid lanes starting at lane 0.
  always_comb begin
    n_enq = '0;
    for (int i = 0; i < ENQ_W; i++)
      if (q.enq_valid[i] && int'(n_enq) == i)
        n_enq = NW'(i + 1);
  end

  always_comb begin
    n_deq = q.deq_take;
    if (int'(n_deq) > DEQ_W)
      n_deq = TW'(DEQ_W);
    if (int'(n_deq) > int'(cnt))
      n_deq = TW'(cnt);
  end

  always_comb begin
    head_d = head_q + PW'(n_deq);
    tail_d = tail_q;
    if (fire)
      tail_d = tail_q + PW'(n_enq);
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_W; i++)
      if (fire && i < int'(n_enq))
        mem_q[IW'(tail_q + PW'(i))] <= q.enq_data[i];
  end

  assign q.count     = cnt;
  assign q.enq_ready = ready;

  always_comb begin
    for (int i = 0; i < DEQ_W; i++) begin
      q.deq_valid[i] = int'(cnt) > i;
      q.deq_data[i]  = '0;
      if (int'(cnt) > i)
        q.deq_data[i] = mem_q[IW'(head_q + PW'(i))];
      q.deq_data[i].valid = int'(cnt) > i;
    end
  end

  ap_take_range: assert property (
    @(posedge clk) disable iff (!rst_n) int'(q.deq_take) <= DEQ_W
  );
endmodule

// File: tb/tb_fetch_instr_queue.sv
// Bench for fetch_instr_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_fetch_instr_queue;
  import fetch_instr_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int ENQ_W = 2;
  localparam int DEQ_W = 2;

  typedef struct packed {
    logic [4:0]      cnt;
    logic            rdy;
    logic [1:0]      dv;
    pc_instr_t [1:0] dd;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int checks = 0;
  int failures = 0;
  int tail_pos = 0;
  pc_instr_t mq[$];
  pc_instr_t Z;

  fetch_instr_queue_if #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) bus();

  fetch_instr_queue #(
    .DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .q(bus)
  );

  always #5 clk = ~clk;

  function automatic pc_instr_t mk(input logic [31:0] pc);
    pc_instr_t e;
    e.valid = 1'($urandom);
    e.pc = pc;
    e.instr = $urandom;
    e.br_taken_pred = 1'($urandom);
    return e;
  endfunction

  function automatic obs_t expect_m();
    obs_t e;
    e = '0;
    e.cnt = 5'(mq.size());
    e.rdy = (DEPTH - mq.size()) >= ENQ_W;
    for (int i = 0; i < DEQ_W; i++)
      if (mq.size() > i) begin
        e.dv[i] = 1'b1;
        e.dd[i] = mq[i];
        e.dd[i].valid = 1'b1;
      end
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.cnt = bus.count;
    o.rdy = bus.enq_ready;
    o.dv = bus.deq_valid;
    o.dd = bus.deq_data;
    return o;
  endfunction

  // One clock: drive inputs, advance the model at the edge, settle.
  task automatic cycle(input logic [1:0] v, input pc_instr_t d0,
                       input pc_instr_t d1, input logic [1:0] take,
                       input logic fl);
    int nd;
    bit rdy;
    bus.enq_valid = v;
    bus.enq_data[0] = d0;
    bus.enq_data[1] = d1;
    bus.deq_take = take;
    flush = fl;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      tail_pos = 0;
    end else begin
      rdy = (DEPTH - mq.size()) >= ENQ_W;
      nd = int'(take);
      if (nd > mq.size()) nd = mq.size();
      repeat (nd) void'(mq.pop_front());
      if (rdy && v[0]) begin
        mq.push_back(d0);
        tail_pos++;
        if (v[1]) begin
          mq.push_back(d1);
          tail_pos++;
        end
      end
    end
    #1;
    bus.enq_valid = '0;
    bus.deq_take = '0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (bus.count !== 5'd0) begin
      failures++;
      $display("FAIL reset_count: got %0d want 0", bus.count);
    end
    checks++;
    if (bus.enq_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b want 1", bus.enq_ready);
    end
    checks++;
    if (bus.deq_valid !== 2'b00) begin
      failures++;
      $display("FAIL reset_dv: got %b want 00", bus.deq_valid);
    end
    checks++;
    if (bus.deq_data !== '0) begin
      failures++;
      $display("FAIL reset_dd: got %h want 0", bus.deq_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    tail_pos = 0;
  endtask

  task automatic test_basic();
    cycle(2'b11, mk(32'h1000), mk(32'h1004), 2'd0, 1'b0);
    checks++;
    if (bus.count !== 5'd2 || bus.deq_valid !== 2'b11) begin
      failures++;
      $display("FAIL basic_cnt: got cnt=%0d dv=%b want 2 11",
               bus.count, bus.deq_valid);
    end
    checks++;
    if (bus.deq_data[0].pc !== 32'h1000 || bus.deq_data[1].pc !== 32'h1004) begin
      failures++;
      $display("FAIL basic_pc: got %h %h want 1000 1004",
               bus.deq_data[0].pc, bus.deq_data[1].pc);
    end
    checks++;
    if (observe() !== expect_m()) begin
      failures++;
      $display("FAIL basic_bundle: got %h want %h", observe(), expect_m());
    end
    cycle(2'b00, Z, Z, 2'd1, 1'b0);
    checks++;
    if (bus.deq_data[0].pc !== 32'h1004 || bus.deq_valid !== 2'b01) begin
      failures++;
      $display("FAIL basic_pop1: got pc=%h dv=%b want 1004 01",
               bus.deq_data[0].pc, bus.deq_valid);
    end
    cycle(2'b00, Z, Z, 2'd1, 1'b0);
  endtask

  task automatic test_full();
    for (int k = 0; k < 8; k++)
      cycle(2'b11, mk(32'h1100 + 8 * k), mk(32'h1104 + 8 * k), 2'd0, 1'b0);
    checks++;
    if (bus.count !== 5'd16 || bus.enq_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_state: got cnt=%0d rdy=%b want 16 0",
               bus.count, bus.enq_ready);
    end
    cycle(2'b11, mk(32'h2000), mk(32'h2004), 2'd0, 1'b0);
    checks++;
    if (bus.count !== 5'd16 || bus.deq_data[0].pc !== 32'h1100) begin
      failures++;
      $display("FAIL full_ignore: got cnt=%0d pc=%h want 16 1100",
               bus.count, bus.deq_data[0].pc);
    end
    cycle(2'b00, Z, Z, 2'd2, 1'b0);
    checks++;
    if (bus.count !== 5'd14 || bus.enq_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_pop: got cnt=%0d rdy=%b want 14 1",
               bus.count, bus.enq_ready);
    end
  endtask

  task automatic test_no_credit();
    cycle(2'b01, mk(32'h5000), Z, 2'd0, 1'b0);
    checks++;
    if (bus.count !== 5'd15 || bus.enq_ready !== 1'b0) begin
      failures++;
      $display("FAIL nocred_15: got cnt=%0d rdy=%b want 15 0",
               bus.count, bus.enq_ready);
    end
    cycle(2'b11, mk(32'h6000), mk(32'h6004), 2'd2, 1'b0);
    checks++;
    if (bus.count !== 5'd13) begin
      failures++;
      $display("FAIL nocred_13: got cnt=%0d want 13", bus.count);
    end
    while (mq.size() > 0) begin
      cycle(2'b00, Z, Z, 2'd2, 1'b0);
      checks++;
      if (observe() !== expect_m()) begin
        failures++;
        $display("FAIL nocred_drain: got %h want %h", observe(), expect_m());
      end
    end
  endtask

  task automatic test_stream();
    logic [31:0] want;
    if (tail_pos % 2 == 0)
      cycle(2'b01, mk(32'h6ff0), Z, 2'd0, 1'b0);
    cycle(2'b01, mk(32'h7000), Z, 2'd0, 1'b0);
    cycle(2'b00, Z, Z, 2'd1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      cycle(2'b11, mk(32'h8000 + 8 * k), mk(32'h8004 + 8 * k), 2'd2, 1'b0);
      want = 32'h8000 + 32'(8 * k);
      checks++;
      if (bus.deq_data[0].pc !== want || observe() !== expect_m()) begin
        failures++;
        $display("FAIL stream_%0d: got pc=%h %h want pc=%h %h",
                 k, bus.deq_data[0].pc, observe(), want, expect_m());
      end
    end
    cycle(2'b00, Z, Z, 2'd2, 1'b0);
    checks++;
    if (bus.count !== 5'd0) begin
      failures++;
      $display("FAIL stream_end: got cnt=%0d want 0", bus.count);
    end
  endtask

  task automatic test_partial();
    cycle(2'b10, mk(32'h3000), mk(32'h3000), 2'd0, 1'b0);
    checks++;
    if (bus.count !== 5'd0) begin
      failures++;
      $display("FAIL lane1_only: got cnt=%0d want 0", bus.count);
    end
    cycle(2'b01, mk(32'h3004), mk(32'h3008), 2'd0, 1'b0);
    checks++;
    if (bus.count !== 5'd1 || bus.deq_data[0].pc !== 32'h3004) begin
      failures++;
      $display("FAIL lane0_only: got cnt=%0d pc=%h want 1 3004",
               bus.count, bus.deq_data[0].pc);
    end
    cycle(2'b00, Z, Z, 2'd2, 1'b0);
    checks++;
    if (bus.count !== 5'd0 || bus.deq_valid !== 2'b00) begin
      failures++;
      $display("FAIL overpop: got cnt=%0d dv=%b want 0 00",
               bus.count, bus.deq_valid);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++)
      cycle(2'b11, mk(32'h4800 + 8 * k), mk(32'h4804 + 8 * k), 2'd0, 1'b0);
    checks++;
    if (bus.count !== 5'd6) begin
      failures++;
      $display("FAIL flush_pre: got cnt=%0d want 6", bus.count);
    end
    cycle(2'b11, mk(32'h4100), mk(32'h4104), 2'd2, 1'b1);
    checks++;
    if (bus.count !== 5'd0 || bus.deq_valid !== 2'b00 || bus.deq_data !== '0) begin
      failures++;
      $display("FAIL flush_clear: got cnt=%0d dv=%b dd=%h want 0 00 0",
               bus.count, bus.deq_valid, bus.deq_data);
    end
    cycle(2'b01, mk(32'h4000), Z, 2'd0, 1'b0);
    checks++;
    if (bus.deq_data[0].pc !== 32'h4000 || bus.count !== 5'd1) begin
      failures++;
      $display("FAIL flush_redirect: got pc=%h cnt=%0d want 4000 1",
               bus.deq_data[0].pc, bus.count);
    end
    cycle(2'b00, Z, Z, 2'd1, 1'b0);
  endtask

  task automatic test_async_reset();
    cycle(2'b11, mk(32'h9100), mk(32'h9104), 2'd0, 1'b0);
    cycle(2'b11, mk(32'h9108), mk(32'h910c), 2'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.count !== 5'd0 || bus.deq_valid !== 2'b00 ||
        bus.enq_ready !== 1'b1 || bus.deq_data !== '0) begin
      failures++;
      $display("FAIL async_rst: got cnt=%0d dv=%b rdy=%b want 0 00 1",
               bus.count, bus.deq_valid, bus.enq_ready);
    end
    mq.delete();
    tail_pos = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(2'b11, mk(32'h9000), mk(32'h9004), 2'd0, 1'b0);
    checks++;
    if (bus.count !== 5'd2 || bus.deq_data[0].pc !== 32'h9000) begin
      failures++;
      $display("FAIL rst_first_enq: got cnt=%0d pc=%h want 2 9000",
               bus.count, bus.deq_data[0].pc);
    end
  endtask

  task automatic test_random();
    logic [1:0] v;
    logic [1:0] take;
    logic fl;
    for (int c = 0; c < 400; c++) begin
      v = 2'($urandom);
      take = (c < 200) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(1, 2));
      fl = ($urandom_range(0, 39) == 0);
      cycle(v, mk($urandom), mk($urandom), take, fl);
      checks++;
      if (observe() !== expect_m()) begin
        failures++;
        $display("FAIL random_%0d: got %h want %h", c, observe(), expect_m());
      end
    end
  endtask

  initial begin
    Z = '0;
    bus.enq_valid = '0;
    bus.enq_data = '0;
    bus.deq_take = '0;
    test_reset();
    test_basic();
    test_full();
    test_no_credit();
    test_stream();
    test_partial();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
